jstk_poller: RTL and testbench
==============================

Name: jstk_poller

Overview:
- Downstream/control stage for the SPI master that talks to the PMOD joystick.
- Periodically requests a 40-bit transfer and drives the LED command bytes.
- Waits for the transfer to complete, then decodes the received bytes into X/Y position and buttons.
- Produces a registered sample with a valid pulse, plus thresholded paddle up/down controls for the game logic.

Parameters:
- POLL_CYCLES, 50000, clk cycles from start of one poll to start of the next (1 ms at 50 MHz); minimum 64.
- TRIG_TIMEOUT, 64, max clk cycles trigger is held waiting for busy to assert.
- XFER_TIMEOUT, 4096, max clk cycles spent busy before abort.
- DEAD_LO, 10'd400, Y at or below this value asserts paddle_down.
- DEAD_HI, 10'd624, Y at or above this value asserts paddle_up.

Ports:
- clk  input  1  50 MHz global clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  polling allowed when 1
- leds  input  2  LED1/LED2 request, sent in command byte
- trigger  output  1  to SPI master; starts a transfer
- out_bytes  output  40  to SPI master; command frame
- in_bytes  input  40  from SPI master; last received frame
- cs  input  1  SPI master chip-select, active-low; busy = ~cs
- x_pos  output  10  decoded X
- y_pos  output  10  decoded Y
- buttons  output  3  {btn2, btn1, stick_btn}
- sample_valid  output  1  one-cycle pulse when x/y/buttons update
- paddle_up  output  1  level, held from last good sample
- paddle_down  output  1  level, held from last good sample
- xfer_error  output  1  one-cycle pulse on any timeout

Behaviour:
- Synchronisation: cs passes through a 2-flop synchroniser (cs_s), reset value 1. All decisions use cs_s.
- Reset values:
  - trigger = 0; sample_valid = 0; xfer_error = 0.
  - x_pos = 512; y_pos = 512; buttons = 0.
  - paddle_up = 0; paddle_down = 0.
  - poll counter = 0; state = IDLE.
- out_bytes: registered, updated every cycle in IDLE only, = {6'b100000, leds[1:0], 32'h0}. Frozen while a transfer is in flight.
- IDLE:
  - Poll counter counts while enable = 1 and holds at 0 while enable = 0.
  - When the count reaches POLL_CYCLES-1 and cs_s = 1, the counter clears and the state goes to TRIG.
  - If cs_s = 0 at that point (master busy from elsewhere), stay in IDLE until cs_s = 1, then go to TRIG.
- TRIG:
  - trigger = 1. The master samples trigger on its divided clock (clk/4), so trigger is held until cs_s = 0 is seen.
  - On cs_s = 0 → BUSY, with trigger deasserted the same cycle.
  - If TRIG_TIMEOUT cycles elapse without cs_s = 0: trigger → 0, xfer_error pulses, → IDLE.
- BUSY:
  - Count cycles while cs_s = 0.
  - On cs_s = 1 → SETTLE.
  - If the count reaches XFER_TIMEOUT: xfer_error pulses, → IDLE, outputs unchanged.
- SETTLE:
  - Wait 4 clk cycles (one SPI clock period) so in_bytes is stable, then → LATCH.
- LATCH (1 cycle), decode of in_bytes, first received byte at [39:32]:
  - x_pos = {in_bytes[25:24], in_bytes[39:32]}
  - y_pos = {in_bytes[9:8], in_bytes[23:16]}
  - buttons = in_bytes[2:0]
  - paddle_up = (y ≥ DEAD_HI); paddle_down = (y ≤ DEAD_LO). Comparisons are unsigned 10-bit. Exactly one or neither asserts, given DEAD_LO < DEAD_HI.
  - sample_valid pulses in the cycle after LATCH, aligned with the new output values.
  - → IDLE.
- enable deasserted mid-transfer: the current transfer completes normally; no new poll starts.
- reset mid-transfer: everything returns to reset values immediately. Any in-flight master transfer is ignored and finishes on its own. The first new poll occurs no earlier than POLL_CYCLES after reset release.
- Poll period is measured IDLE-to-IDLE entry. The counter does not run during TRIG/BUSY/SETTLE/LATCH.

Test Plan:
- Reset, enable = 1, leds = 2'b01, SPI model returns 40'h8C_02_37_01_05 → trigger rises at cycle POLL_CYCLES; out_bytes = 40'h81_00000000; then x_pos = 0x28C, y_pos = 0x137, buttons = 3'b101, paddle_up = 0, paddle_down = 1 (0x137 = 311 ≤ 400); one sample_valid pulse.
- Y = 700 returned → paddle_up = 1, paddle_down = 0. Y = 512 → both 0. Y = 400 and Y = 624 → boundary inclusive (down = 1; up = 1 respectively).
- SPI model never lowers cs → trigger held exactly TRIG_TIMEOUT cycles, xfer_error pulses once, outputs unchanged, next attempt after another POLL_CYCLES.
- cs held low indefinitely after trigger → xfer_error after XFER_TIMEOUT busy cycles, no sample_valid.
- Assert reset while in BUSY → all outputs at reset values next cycle; state IDLE; no sample_valid for the aborted transfer.
- enable = 0 for 3 poll periods then 1 → no trigger during disable; first trigger POLL_CYCLES after re-enable; leds change during BUSY does not alter out_bytes until IDLE.

Source files
------------

// File: rtl/jstk_poller.sv
// jstk_poller: periodic poll controller for the PMOD joystick SPI master.
// Requests a 40-bit transfer every POLL_CYCLES, waits for the master to
// finish, then decodes X/Y/buttons and derives thresholded paddle controls.
module jstk_poller #(
    parameter int unsigned POLL_CYCLES  = 50000,
    parameter int unsigned TRIG_TIMEOUT = 64,
    parameter int unsigned XFER_TIMEOUT = 4096,
    parameter logic [9:0]  DEAD_LO      = 10'd400,
    parameter logic [9:0]  DEAD_HI      = 10'd624
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  leds,
    output logic        trigger,
    output logic [39:0] out_bytes,
    input  logic [39:0] in_bytes,
    input  logic        cs,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [2:0]  buttons,
    output logic        sample_valid,
    output logic        paddle_up,
    output logic        paddle_down,
    output logic        xfer_error
);

    typedef enum logic [2:0] {IDLE, TRIG, BUSY, SETTLE, LATCH} state_t;

    state_t      state;
    logic        cs_m;
    logic        cs_s;
    logic [31:0] poll_cnt;
    logic [31:0] timer;
    logic [9:0]  y_new;
    logic        unused_in;

    assign y_new     = {in_bytes[9:8], in_bytes[23:16]};
    assign unused_in = ^{in_bytes[31:26], in_bytes[15:10], in_bytes[7:3]};

    // Two-flop synchroniser for the master's chip-select (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_m <= 1'b1;
            cs_s <= 1'b1;
        end else begin
            cs_m <= cs;
            cs_s <= cs_m;
        end
    end

    // Poll / trigger / wait / decode sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            poll_cnt     <= '0;
            timer        <= '0;
            trigger      <= 1'b0;
            out_bytes    <= 40'h80_0000_0000;
            x_pos        <= 10'd512;
            y_pos        <= 10'd512;
            buttons      <= '0;
            sample_valid <= 1'b0;
            paddle_up    <= 1'b0;
            paddle_down  <= 1'b0;
            xfer_error   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            xfer_error   <= 1'b0;
            case (state)
                IDLE: begin
                    out_bytes <= {6'b100000, leds, 32'h0};
                    if (!enable) begin
                        poll_cnt <= '0;
                    end else if (poll_cnt == POLL_CYCLES - 1) begin
                        // Period elapsed: hold here until the master is free.
                        if (cs_s) begin
                            poll_cnt <= '0;
                            timer    <= '0;
                            trigger  <= 1'b1;
                            state    <= TRIG;
                        end
                    end else begin
                        poll_cnt <= poll_cnt + 32'd1;
                    end
                end
                TRIG: begin
                    if (!cs_s) begin
                        trigger <= 1'b0;
                        timer   <= '0;
                        state   <= BUSY;
                    end else if (timer == TRIG_TIMEOUT - 1) begin
                        trigger    <= 1'b0;
                        xfer_error <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                BUSY: begin
                    if (cs_s) begin
                        timer <= '0;
                        state <= SETTLE;
                    end else if (timer == XFER_TIMEOUT - 1) begin
                        xfer_error <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                SETTLE: begin
                    // One SPI clock period (clk/4) for in_bytes to settle.
                    if (timer == 32'd3) begin
                        state <= LATCH;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                LATCH: begin
                    x_pos        <= {in_bytes[25:24], in_bytes[39:32]};
                    y_pos        <= y_new;
                    buttons      <= in_bytes[2:0];
                    paddle_up    <= (y_new >= DEAD_HI);
                    paddle_down  <= (y_new <= DEAD_LO);
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_poller.sv
// tb_jstk_poller: scoreboard bench for jstk_poller with a behavioural SPI master.
module tb_jstk_poller;

    localparam int P        = 64;
    localparam int T        = 16;
    localparam int X        = 128;
    localparam int BUSY_LEN = 20;
    localparam int BOUND    = 4 * P + 2 * X;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  leds = 2'b00;
    logic        trigger;
    logic [39:0] out_bytes;
    logic [39:0] in_bytes;
    logic        cs;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [2:0]  buttons;
    logic        sample_valid;
    logic        paddle_up;
    logic        paddle_down;
    logic        xfer_error;

    jstk_poller #(
        .POLL_CYCLES (P),
        .TRIG_TIMEOUT(T),
        .XFER_TIMEOUT(X),
        .DEAD_LO     (10'd400),
        .DEAD_HI     (10'd624)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .leds        (leds),
        .trigger     (trigger),
        .out_bytes   (out_bytes),
        .in_bytes    (in_bytes),
        .cs          (cs),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buttons     (buttons),
        .sample_valid(sample_valid),
        .paddle_up   (paddle_up),
        .paddle_down (paddle_down),
        .xfer_error  (xfer_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
        logic       up;
        logic       dn;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          valid_pulses = 0;
    int          err_pulses = 0;
    int          mode = 0;          // 0 normal, 1 never lowers cs, 2 holds cs low
    logic [39:0] frame = '0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] make_frame(input logic [9:0] x, input logic [9:0] y,
                                               input logic [2:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

    task automatic expect_sample(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                                 input logic up, input logic dn);
        exp_t e;
        e.x = x; e.y = y; e.b = b; e.up = up; e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Behavioural SPI master: answers trigger by pulling cs low, then returns frame.
    initial begin
        cs = 1'b1;
        in_bytes = '0;
        forever begin
            @(negedge clk);
            if (trigger && mode != 1) begin
                repeat (3) @(negedge clk);
                cs = 1'b0;
                while (mode == 2) @(negedge clk);
                repeat (BUSY_LEN) @(negedge clk);
                in_bytes = frame;
                cs = 1'b1;
                repeat (2) @(negedge clk);
            end
        end
    end

    // Monitor: pops the scoreboard on every sample_valid, counts error pulses.
    always @(negedge clk) begin
        exp_t e;
        if (xfer_error) err_pulses++;
        if (sample_valid) begin
            valid_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample x=%0h y=%0h expected none", x_pos, y_pos);
            end else begin
                e = exp_q.pop_front();
                check("x_pos", 40'(x_pos), 40'(e.x));
                check("y_pos", 40'(y_pos), 40'(e.y));
                check("buttons", 40'(buttons), 40'(e.b));
                check("paddle_up", 40'(paddle_up), 40'(e.up));
                check("paddle_down", 40'(paddle_down), 40'(e.dn));
            end
        end
    end

    // Counts posedges until trigger is seen high at a negedge (BOUND+1 on expiry).
    task automatic wait_trigger(output int n);
        n = 0;
        while (n <= BOUND) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (trigger) break;
        end
    endtask

    task automatic wait_valid(input string name);
        int prev;
        int k;
        prev = valid_pulses;
        k = 0;
        while (valid_pulses == prev && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check(name, 40'(valid_pulses), 40'(prev + 1));
    endtask

    task automatic wait_cs_low();
        int k;
        k = 0;
        while (k < BOUND) begin
            @(posedge clk);
            k++;
            if (!cs) break;
        end
    endtask

    logic [9:0] ty [6] = '{10'd512, 10'd400, 10'd624, 10'd401, 10'd623, 10'd700};
    logic [9:0] tx [6] = '{10'h001, 10'h3FF, 10'h200, 10'h0AA, 10'h155, 10'h123};
    logic [2:0] tb_ [6] = '{3'b000, 3'b111, 3'b010, 3'b100, 3'b001, 3'b110};
    logic       tup [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tdn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int n;
        int v0;
        int e0;
        int trig_rises;

        repeat (3) @(negedge clk);
        check("reset_outputs", 40'({x_pos, y_pos, buttons, paddle_up, paddle_down,
                                    trigger, sample_valid, xfer_error}),
              40'({10'd512, 10'd512, 3'b000, 5'b00000}));

        // First poll: trigger after exactly P cycles, command byte carries leds.
        frame = 40'h8C_02_37_01_05;
        expect_sample(10'h28C, 10'h137, 3'b101, 1'b0, 1'b1);
        leds = 2'b01;
        enable = 1'b1;
        reset = 1'b0;
        wait_trigger(n);
        check("first_trigger_cycle", 40'(n), 40'(P));
        check("out_bytes_leds01", out_bytes, 40'h81_0000_0000);
        wait_valid("first_sample_valid");

        // Threshold boundaries on Y.
        for (int i = 0; i < 6; i++) begin
            frame = make_frame(tx[i], ty[i], tb_[i]);
            expect_sample(tx[i], ty[i], tb_[i], tup[i], tdn[i]);
            wait_valid("table_sample_valid");
        end

        // Master never responds: trigger held T cycles, one error, outputs held.
        mode = 1;
        e0 = err_pulses;
        v0 = valid_pulses;
        wait_trigger(n);
        n = 1;
        while (n <= T + 4) begin
            @(negedge clk);
            if (!trigger) break;
            n++;
        end
        check("trig_hold_cycles", 40'(n), 40'(T));
        check("trig_timeout_error", 40'(xfer_error), 40'(1));
        mode = 0;
        frame = make_frame(10'h0F0, 10'd700, 3'b011);
        expect_sample(10'h0F0, 10'd700, 3'b011, 1'b1, 1'b0);
        wait_trigger(n);
        check("retry_after_timeout", 40'(n), 40'(P));
        check("trig_timeout_held_y", 40'({y_pos, paddle_up}), 40'({10'd700, 1'b1}));
        check("trig_timeout_err_count", 40'(err_pulses), 40'(e0 + 1));
        check("trig_timeout_no_valid", 40'(valid_pulses), 40'(v0));
        wait_valid("retry_sample_valid");

        // Master holds cs low: error after X busy cycles (+3 for sync and entry).
        mode = 2;
        e0 = err_pulses;
        v0 = valid_pulses;
        wait_cs_low();
        n = 1;
        while (n <= X + 20) begin
            @(negedge clk);
            if (xfer_error) break;
            @(posedge clk);
            n++;
        end
        check("busy_timeout_cycles", 40'(n), 40'(X + 3));
        check("busy_timeout_held_x", 40'(x_pos), 40'(10'h0F0));
        check("busy_timeout_no_valid", 40'(valid_pulses), 40'(v0));
        frame = make_frame(10'h321, 10'd700, 3'b001);
        expect_sample(10'h321, 10'd700, 3'b001, 1'b1, 1'b0);
        mode = 0;
        wait_valid("busy_recovery_valid");
        check("busy_timeout_err_count", 40'(err_pulses), 40'(e0 + 1));

        // Reset during BUSY: immediate return to reset values, no late sample.
        frame = make_frame(10'h2AA, 10'd100, 3'b111);
        wait_cs_low();
        repeat (5) @(negedge clk);
        v0 = valid_pulses;
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("reset_in_busy", 40'({x_pos, y_pos, buttons, paddle_up, paddle_down,
                                    trigger, sample_valid, xfer_error}),
              40'({10'd512, 10'd512, 3'b000, 5'b00000}));
        reset = 1'b0;

        // Disabled for three poll periods: no trigger, no sample.
        trig_rises = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (trigger) trig_rises++;
        end
        check("no_trigger_disabled", 40'(trig_rises), 40'(0));
        check("no_valid_after_abort", 40'(valid_pulses), 40'(v0));

        // Re-enable: trigger P cycles later; leds changed mid-transfer are not sent.
        leds = 2'b10;
        frame = make_frame(10'h155, 10'd0, 3'b010);
        expect_sample(10'h155, 10'd0, 3'b010, 1'b0, 1'b1);
        enable = 1'b1;
        wait_trigger(n);
        check("reenable_trigger_cycle", 40'(n), 40'(P));
        check("out_bytes_leds10", out_bytes, 40'h82_0000_0000);
        wait_cs_low();
        leds = 2'b11;
        repeat (6) @(negedge clk);
        check("out_bytes_frozen_busy", out_bytes, 40'h82_0000_0000);
        wait_valid("reenable_sample_valid");
        repeat (2) @(negedge clk);
        check("out_bytes_leds11_idle", out_bytes, 40'h83_0000_0000);
        check("scoreboard_empty", 40'(exp_q.size()), 40'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
